// File: rtl/count_decoder_pkg.sv
// count_decoder_pkg: shared types for the count direction decoder.
//   state_e       - decoder FSM states
//   delta_class_e - classification of (Count - prev) mod 2^WIDTH
//   STEP_W_DEFAULT - default width of the step accumulator
package count_decoder_pkg;

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_IDLE  = 2'd1,
        S_UP    = 2'd2,
        S_DOWN  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        D_HOLD = 2'd0,
        D_INC  = 2'd1,
        D_DEC  = 2'd2,
        D_JUMP = 2'd3
    } delta_class_e;

    localparam int unsigned STEP_W_DEFAULT = 16;

endpackage

// File: rtl/count_delta_classify.sv
// count_delta_classify: combinational classifier of a count change.
// Ports:
//   prev   in  WIDTH  last qualified count
//   count  in  WIDTH  current count
//   dclass out 2      delta_class_e encoding (hold / +1 / -1 / jump)
//   wrap   out 1      step crosses the modular boundary (max->0 up, 0->max down)
module count_delta_classify
    import count_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count,
    output logic [1:0]       dclass,
    output logic             wrap
);

    logic [WIDTH-1:0] delta;

    // Modular difference; wraps naturally at WIDTH bits.
    assign delta = count - prev;

    always_comb begin
        dclass = D_JUMP;
        if (delta == '0) begin
            dclass = D_HOLD;
        end else if (delta == WIDTH'(1)) begin
            dclass = D_INC;
        end else if (delta == '1) begin
            dclass = D_DEC;
        end
        wrap = ((dclass == D_INC) && (prev == '1)) ||
               ((dclass == D_DEC) && (prev == '0));
    end

endmodule

// File: rtl/count_direction_decoder.sv
// count_direction_decoder: watches a modular count bus and turns it into events.
// Optional feature macro: COUNT_DIRECTION_DECODER_REVERSAL_EN (adds reversal outputs).
// Ports:
//   Clk            in   1       rising-edge clock
//   reset          in   1       asynchronous active-high reset
//   Count          in   WIDTH   observed count
//   sample_en      in   1       qualifies Count this cycle
//   UpOrDown       out  1       direction, 1 = up (valid while dir_valid)
//   dir_valid      out  1       direction established since prime/error/reset
//   step           out  1       pulse per legal +/-1 change
//   wrap           out  1       pulse on max->0 up or 0->max down step
//   error          out  1       pulse on an illegal jump
//   stalled        out  1       level, count unchanged for >= HOLD_LIMIT samples
//   step_count     out  STEP_W  saturating count of legal steps
//   reversal       out  1       (macro only) pulse on an up<->down transition
//   reversal_count out  8       (macro only) saturating count of reversals
module count_direction_decoder
    import count_decoder_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned HOLD_LIMIT = 8,
    parameter int unsigned STEP_W     = STEP_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  Count,
    input  logic              sample_en,
    output logic              UpOrDown,
    output logic              dir_valid,
    output logic              step,
    output logic              wrap,
    output logic              error,
    output logic              stalled,
    output logic [STEP_W-1:0] step_count
`ifdef COUNT_DIRECTION_DECODER_REVERSAL_EN
    ,
    output logic              reversal,
    output logic [7:0]        reversal_count
`endif
);

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_LIMIT);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [7:0]          hold_q, hold_d;
    logic                updown_q, updown_d;
    logic                dir_valid_q, dir_valid_d;
    logic                step_q, step_d;
    logic                wrap_q, wrap_d;
    logic                error_q, error_d;
    logic                stalled_q, stalled_d;
    logic [STEP_W-1:0]   step_count_q, step_count_d;
    logic                rev_q, rev_d;
    logic [7:0]          rev_count_q, rev_count_d;

    logic [1:0]          dclass_raw;
    delta_class_e        dclass;
    logic                cls_wrap;

    count_delta_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .prev   (prev_q),
        .count  (Count),
        .dclass (dclass_raw),
        .wrap   (cls_wrap)
    );

    assign dclass = delta_class_e'(dclass_raw);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        hold_d       = hold_q;
        updown_d     = updown_q;
        dir_valid_d  = dir_valid_q;
        stalled_d    = stalled_q;
        step_count_d = step_count_q;
        rev_count_d  = rev_count_q;
        step_d       = 1'b0;
        wrap_d       = 1'b0;
        error_d      = 1'b0;
        rev_d        = 1'b0;

        if (sample_en) begin
            prev_d = Count;
            if (state_q == S_PRIME) begin
                // First qualified sample only establishes a reference.
                state_d = S_IDLE;
            end else begin
                unique case (dclass)
                    D_HOLD: begin
                        if (hold_q != HOLD_MAX) begin
                            hold_d = hold_q + 8'd1;
                        end
                        stalled_d = (hold_d == HOLD_MAX);
                    end
                    D_INC, D_DEC: begin
                        step_d      = 1'b1;
                        wrap_d      = cls_wrap;
                        updown_d    = (dclass == D_INC);
                        state_d     = (dclass == D_INC) ? S_UP : S_DOWN;
                        rev_d       = (dclass == D_INC) ? (state_q == S_DOWN)
                                                        : (state_q == S_UP);
                        dir_valid_d = 1'b1;
                        hold_d      = 8'd0;
                        stalled_d   = 1'b0;
                        if (step_count_q != '1) begin
                            step_count_d = step_count_q + STEP_W'(1);
                        end
                    end
                    default: begin
                        error_d     = 1'b1;
                        state_d     = S_IDLE;
                        dir_valid_d = 1'b0;
                        hold_d      = 8'd0;
                        stalled_d   = 1'b0;
                    end
                endcase
                if (rev_d && (rev_count_q != 8'hff)) begin
                    rev_count_d = rev_count_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_PRIME;
            prev_q       <= '0;
            hold_q       <= 8'd0;
            updown_q     <= 1'b0;
            dir_valid_q  <= 1'b0;
            step_q       <= 1'b0;
            wrap_q       <= 1'b0;
            error_q      <= 1'b0;
            stalled_q    <= 1'b0;
            step_count_q <= '0;
            rev_q        <= 1'b0;
            rev_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            hold_q       <= hold_d;
            updown_q     <= updown_d;
            dir_valid_q  <= dir_valid_d;
            step_q       <= step_d;
            wrap_q       <= wrap_d;
            error_q      <= error_d;
            stalled_q    <= stalled_d;
            step_count_q <= step_count_d;
            rev_q        <= rev_d;
            rev_count_q  <= rev_count_d;
        end
    end

    assign UpOrDown   = updown_q;
    assign dir_valid  = dir_valid_q;
    assign step       = step_q;
    assign wrap       = wrap_q;
    assign error      = error_q;
    assign stalled    = stalled_q;
    assign step_count = step_count_q;

`ifdef COUNT_DIRECTION_DECODER_REVERSAL_EN
    assign reversal       = rev_q;
    assign reversal_count = rev_count_q;
`else
    // Reversal tracking collapses away when its outputs are not present.
    logic unused_rev;
    assign unused_rev = rev_q ^ (^rev_count_q);
`endif

endmodule

// File: tb/tb_count_direction_decoder.sv
// Scoreboard bench for count_direction_decoder (WIDTH=4, HOLD_LIMIT=8).
// Driver pushes hand-computed expected outputs; monitor pops and compares after each edge.
module tb_count_direction_decoder;

    typedef struct packed {
        logic        ud;
        logic        dv;
        logic        st;
        logic        wr;
        logic        er;
        logic        sl;
        logic [15:0] sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  count = 4'd0;
    logic        sample_en = 1'b0;
    logic        ud, dv, st, wr, er, sl;
    logic [15:0] sc;
`ifdef COUNT_DIRECTION_DECODER_REVERSAL_EN
    logic        rev;
    logic [7:0]  rev_cnt;
`endif

    int   n_total = 0;
    int   n_pass  = 0;
    int   vec_id  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    count_direction_decoder #(
        .WIDTH      (4),
        .HOLD_LIMIT (8),
        .STEP_W     (16)
    ) dut (
        .Clk        (clk),
        .reset      (reset),
        .Count      (count),
        .sample_en  (sample_en),
        .UpOrDown   (ud),
        .dir_valid  (dv),
        .step       (st),
        .wrap       (wr),
        .error      (er),
        .stalled    (sl),
        .step_count (sc)
`ifdef COUNT_DIRECTION_DECODER_REVERSAL_EN
        ,
        .reversal       (rev),
        .reversal_count (rev_cnt)
`endif
    );

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = '{ud: ud, dv: dv, st: st, wr: wr, er: er, sl: sl, sc: sc};
        n_total++;
        if (a !== e) begin
            $display("FAIL %s: got ud=%b dv=%b step=%b wrap=%b err=%b stall=%b cnt=%0d, want ud=%b dv=%b step=%b wrap=%b err=%b stall=%b cnt=%0d",
                     name, a.ud, a.dv, a.st, a.wr, a.er, a.sl, a.sc,
                     e.ud, e.dv, e.st, e.wr, e.er, e.sl, e.sc);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: outputs are registered, so every edge presents a new result.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("vec%0d", vec_id), e);
            vec_id++;
        end
    end

    task automatic drive(input logic en, input logic [3:0] c,
                         input logic e_ud, input logic e_dv, input logic e_st,
                         input logic e_wr, input logic e_er, input logic e_sl,
                         input int e_sc);
        exp_t e;
        @(negedge clk);
        sample_en = en;
        count     = c;
        e = '{ud: e_ud, dv: e_dv, st: e_st, wr: e_wr, er: e_er, sl: e_sl, sc: 16'(e_sc)};
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        sample_en = 1'b0;
        exp_q.push_back('0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset state, then prime and two up steps.
        do_reset();
        //    en c      ud dv st wr er sl sc
        drive(1, 4'd3,  0, 0, 0, 0, 0, 0, 0);
        drive(1, 4'd4,  1, 1, 1, 0, 0, 0, 1);
        drive(1, 4'd5,  1, 1, 1, 0, 0, 0, 2);

        // Up wrap 15 -> 0.
        do_reset();
        drive(1, 4'd14, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 4'd15, 1, 1, 1, 0, 0, 0, 1);
        drive(1, 4'd0,  1, 1, 1, 1, 0, 0, 2);
        drive(1, 4'd1,  1, 1, 1, 0, 0, 0, 3);

        // Hold, then reversal down with wrap 0 -> 15.
        drive(1, 4'd1,  1, 1, 0, 0, 0, 0, 3);
        drive(1, 4'd0,  0, 1, 1, 0, 0, 0, 4);
        drive(1, 4'd15, 0, 1, 1, 1, 0, 0, 5);
        // Unqualified gap: everything holds, the junk count is ignored.
        drive(0, 4'd9,  0, 1, 0, 0, 0, 0, 5);
        drive(0, 4'd2,  0, 1, 0, 0, 0, 0, 5);
        drive(1, 4'd14, 0, 1, 1, 0, 0, 0, 6);

        // Illegal jumps, then resume up tracking.
        drive(1, 4'd5,  0, 0, 0, 0, 1, 0, 6);
        drive(1, 4'd9,  0, 0, 0, 0, 1, 0, 6);
        drive(1, 4'd10, 1, 1, 1, 0, 0, 0, 7);

        // Jump to 7 then hold: stalled rises on the 8th unchanged sample.
        drive(1, 4'd7,  1, 0, 0, 0, 1, 0, 7);
        for (int i = 1; i <= 10; i++) begin
            drive(1, 4'd7, 1, 0, 0, 0, 0, (i >= 8), 7);
        end
        drive(0, 4'd3,  1, 0, 0, 0, 0, 1, 7);
        drive(1, 4'd8,  1, 1, 1, 0, 0, 0, 8);
        drive(1, 4'd9,  1, 1, 1, 0, 0, 0, 9);

        // Asynchronous reset between edges, with sample_en toggling.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", '0);
        drive(1, 4'd4,  0, 0, 0, 0, 0, 0, 0);
        drive(0, 4'd5,  0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset     = 1'b0;
        sample_en = 1'b0;
        exp_q.push_back('0);
        drive(1, 4'd6,  0, 0, 0, 0, 0, 0, 0);
        drive(1, 4'd7,  1, 1, 1, 0, 0, 0, 1);
        drive(0, 4'd7,  1, 1, 0, 0, 0, 0, 1);

        repeat (3) @(posedge clk);
        #2;
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_direction_decoder.md
# count_direction_decoder

Receive-side companion to the team's 4-bit up/down counter: observes the `Count` bus, recovers direction, step and wrap events, and flags illegal jumps or stalls. Sits downstream of the counter, or of any block that drives a modular count, so monitors and control logic see events instead of raw values. All outputs are registered.

## Interface
- `WIDTH`, default 4: width of the observed count.
- `HOLD_LIMIT`, default 8: number of consecutive qualified unchanged samples before `stalled` asserts. Legal range is 1 to 255.
- `STEP_W`, default 16: width of the step accumulator.

- `Clk`  in  1  single clock. All logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Count`  in  WIDTH  observed counter value, synchronous to `Clk`.
- `sample_en`  in  1  qualifies `Count` for the current cycle. When low, all state holds and all pulses are 0.
- `UpOrDown`  out  1  decoded direction: 1 = up, 0 = down. Valid only while `dir_valid` is 1.
- `dir_valid`  out  1  a direction has been established since the last prime, resync or reset.
- `step`  out  1  one-cycle pulse per legal ±1 change.
- `wrap`  out  1  one-cycle pulse on a max→0 up step or a 0→max down step. Always coincides with `step`.
- `error`  out  1  one-cycle pulse on an illegal jump.
- `stalled`  out  1  level. High while the count has been unchanged for ≥ `HOLD_LIMIT` qualified samples.
- `step_count`  out  STEP_W  saturating total of legal steps since reset.

## Operation
- States: `S_PRIME`, `S_IDLE`, `S_UP`, `S_DOWN`.
- `S_PRIME` (entered at reset): on the first qualified sample, load `prev` ← `Count`, go to `S_IDLE`, emit no pulses.
- In the other states, on each qualified sample compute `delta` = (`Count` − `prev`) mod 2^WIDTH. `prev` ← `Count` in every case.
- `delta` = 0:
  - Hold counter increments, saturating at `HOLD_LIMIT`.
  - `stalled` = 1 when the counter reaches `HOLD_LIMIT`.
  - State is unchanged.
- `delta` = 1:
  - `step` pulses, go to `S_UP`, `UpOrDown` = 1, `dir_valid` = 1.
  - Hold counter and `stalled` clear.
- `delta` = 2^WIDTH − 1:
  - `step` pulses, go to `S_DOWN`, `UpOrDown` = 0, `dir_valid` = 1.
  - Hold counter and `stalled` clear.
- Any other `delta`:
  - `error` pulses, go to `S_IDLE`, `dir_valid` = 0.
  - Hold counter and `stalled` clear.
  - `step_count` is unchanged.
- `wrap`: an up step with `prev` = all-ones, or a down step with `prev` = 0.
- A direction reversal (`S_UP`→`S_DOWN` or the reverse) is legal: `step` pulses and `UpOrDown` flips.
- `step_count` increments by 1 per `step` and saturates at all-ones.
- Reset asserted mid-operation forces every register to its reset value immediately, and the block returns to `S_PRIME`.

## Timing
- Reset values:
  - state = `S_PRIME`, `prev` = 0, hold counter = 0.
  - `UpOrDown` = 0, `dir_valid` = 0, `step`/`wrap`/`error` = 0, `stalled` = 0, `step_count` = 0.
- Latency: a sample taken on edge N is reflected on all outputs after edge N (visible in cycle N+1).
- Pulses are exactly one cycle wide. Back-to-back qualified steps give back-to-back `step` pulses.
- `sample_en` low for any number of cycles: the next qualified sample is compared against the last qualified `prev`. Gaps are invisible.
- `Count` may change every cycle. No handshake or backpressure.

## Configuration
- Macro `COUNT_DIRECTION_DECODER_REVERSAL_EN`.
- Defined:
  - Adds output `reversal` (1 bit, reset 0): a one-cycle pulse on any `S_UP`↔`S_DOWN` transition.
  - Adds output `reversal_count` (8 bits, reset 0): saturating count of reversals.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `count_decoder_pkg` holds:
  - the state enum (`S_PRIME`, `S_IDLE`, `S_UP`, `S_DOWN`);
  - the delta-class enum (`D_HOLD`, `D_INC`, `D_DEC`, `D_JUMP`);
  - a localparam for the default `STEP_W`.
- Sub-module `count_delta_classify`: combinational. Takes `prev`, `Count` and `WIDTH`, and returns the delta class and the wrap flag.
- FSM, hold counter and accumulators live in the top module.

## Test plan
All scenarios use WIDTH=4 and HOLD_LIMIT=8.
- Reset, then `Count` 3,4,5: first sample primes with no pulse. Then two `step` pulses, `UpOrDown`=1, `dir_valid`=1, `step_count`=2.
- Count 14,15,0,1: `wrap` pulses exactly on the 15→0 sample. `step_count`=3.
- Count 1,0,15: down steps. `wrap` pulses on 0→15. `UpOrDown`=0.
- Count 5 then 9: `error` pulses, `dir_valid`=0, `step_count` is unchanged. A following 10 resumes up tracking.
- Count held at 7 for 10 qualified cycles: `stalled` rises after the 8th unchanged sample and clears on the next ±1.
- Reset asserted mid-sequence with `sample_en` toggling: all outputs go to 0 asynchronously. The next qualified sample only primes.
